// File: rtl/usb11_fifo_flex.sv
// Parametrised synchronous FIFO for the USB 1.1 Tx/Rx paths. It provides a registered or
// first-word-fall-through read port, fill-level reporting, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags.
module usb11_fifo_flex #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AFULL_THR  = 48,
   parameter int unsigned AEMPTY_THR = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              push_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              overflow_o,
   output logic              underflow_o,
   input  logic              clr_err_i
);

   localparam int unsigned   DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DepthLvl  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AfullLvl  = (ADDR_W + 1)'(AFULL_THR);
   localparam logic [ADDR_W:0] AemptyLvl = (ADDR_W + 1)'(AEMPTY_THR);
   localparam logic [ADDR_W:0] OneLvl    = (ADDR_W + 1)'(1);

   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_inc;
   logic [ADDR_W:0]   level_q, level_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              empty;
   logic              full;
   logic              pop_ok;
   logic              push_ok;
   logic              wr_en;

   assign empty      = (level_q == '0);
   assign full       = (level_q == DepthLvl);
   assign pop_ok     = pop_i & ~empty;
   // A full FIFO still accepts a push when a word leaves in the same cycle.
   assign push_ok    = push_i & (~full | pop_ok);
   assign wr_en      = push_ok & ~flush_i;
   assign rd_ptr_inc = rd_ptr_q + 1'b1;

   // Next-state for pointers, level, read data and sticky error flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      data_d   = data_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_inc;
         if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
         end
         if (FWFT != 0) begin
            // Keep data_q equal to the head word of the post-edge contents. When the last
            // stored word leaves alongside a push, the incoming word becomes the head.
            if (pop_ok) begin
               data_d = (level_q == OneLvl) ? data_i : mem_q[rd_ptr_inc];
            end else if (empty && push_ok) begin
               data_d = data_i;
            end
         end else begin
            if (pop_ok) data_d = mem_q[rd_ptr_q];
         end
      end
      // A same-cycle set wins over clear.
      ovf_d = (push_i & ~push_ok & ~flush_i) | (ovf_q & ~clr_err_i);
      udf_d = (pop_i & ~pop_ok & ~flush_i) | (udf_q & ~clr_err_i);
   end

   // Control and read-data registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage array; no reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o         = data_q;
   assign full_o         = full;
   assign empty_o        = empty;
   assign level_o        = level_q;
   assign almost_full_o  = (level_q >= AfullLvl);
   assign almost_empty_o = (level_q <= AemptyLvl);
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

endmodule

// File: tb/tb_usb11_fifo_flex.sv
// Directed bench for usb11_fifo_flex: a 64x8 registered-read FIFO, a 4-deep FIFO checked
// against a reference queue, and an 8-deep FWFT FIFO. All instances share the input bus.
module tb_usb11_fifo_flex;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       flush_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       push_i = 1'b0;
   logic       pop_i = 1'b0;
   logic       clr_err_i = 1'b0;

   logic [7:0] a_data, b_data, c_data;
   logic [6:0] a_level;
   logic [2:0] b_level;
   logic [3:0] c_level;
   logic a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic c_full, c_empty, c_af, c_ae, c_ovf, c_udf;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   usb11_fifo_flex #(.WIDTH(8), .ADDR_W(6), .FWFT(0), .AFULL_THR(48), .AEMPTY_THR(4)) u_big (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i), .push_i(push_i),
      .pop_i(pop_i), .data_o(a_data), .full_o(a_full), .empty_o(a_empty), .level_o(a_level),
      .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf), .underflow_o(a_udf),
      .clr_err_i(clr_err_i)
   );

   usb11_fifo_flex #(.WIDTH(8), .ADDR_W(2), .FWFT(0), .AFULL_THR(3), .AEMPTY_THR(1)) u_small (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i), .push_i(push_i),
      .pop_i(pop_i), .data_o(b_data), .full_o(b_full), .empty_o(b_empty), .level_o(b_level),
      .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ovf), .underflow_o(b_udf),
      .clr_err_i(clr_err_i)
   );

   usb11_fifo_flex #(.WIDTH(8), .ADDR_W(3), .FWFT(1), .AFULL_THR(6), .AEMPTY_THR(2)) u_fwft (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i), .push_i(push_i),
      .pop_i(pop_i), .data_o(c_data), .full_o(c_full), .empty_o(c_empty), .level_o(c_level),
      .almost_full_o(c_af), .almost_empty_o(c_ae), .overflow_o(c_ovf), .underflow_o(c_udf),
      .clr_err_i(clr_err_i)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
   endtask

   logic [7:0] q[$];
   logic [7:0] m_data;
   logic       m_ovf, m_udf, pok, wok;

   initial begin
      // Reset
      step(); step();
      rst_i = 1'b0;
      step();
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_full", 32'(a_full), 32'd0);
      chk("rst_level", 32'(a_level), 32'd0);
      chk("rst_afull", 32'(a_af), 32'd0);
      chk("rst_aempty", 32'(a_ae), 32'd1);
      chk("rst_ovf", 32'(a_ovf), 32'd0);
      chk("rst_udf", 32'(a_udf), 32'd0);
      chk("rst_data", 32'(a_data), 32'd0);

      // Fill 64 then drain 64
      for (int i = 0; i < 64; i++) begin
         data_i = 8'(i); push_i = 1'b1;
         step();
         chk("fill_level", 32'(a_level), 32'(i + 1));
         chk("fill_afull", 32'(a_af), 32'((i + 1) >= 48));
         chk("fill_aempty", 32'(a_ae), 32'((i + 1) <= 4));
      end
      idle();
      chk("fill_full", 32'(a_full), 32'd1);
      for (int i = 0; i < 64; i++) begin
         pop_i = 1'b1;
         step();
         chk("drain_data", 32'(a_data), 32'(i));
         chk("drain_level", 32'(a_level), 32'(63 - i));
      end
      idle();
      chk("drain_empty", 32'(a_empty), 32'd1);
      chk("drain_ovf", 32'(a_ovf), 32'd0);
      chk("drain_udf", 32'(a_udf), 32'd0);

      // Overflow and push+pop while full
      for (int i = 0; i < 64; i++) begin
         data_i = 8'(i); push_i = 1'b1;
         step();
      end
      data_i = 8'hAA;
      step();
      chk("ovf_set", 32'(a_ovf), 32'd1);
      chk("ovf_level", 32'(a_level), 32'd64);
      data_i = 8'hBB; pop_i = 1'b1;
      step();
      chk("fullpp_level", 32'(a_level), 32'd64);
      chk("fullpp_data", 32'(a_data), 32'd0);
      chk("fullpp_ovf", 32'(a_ovf), 32'd1);
      idle(); clr_err_i = 1'b1;
      step();
      chk("ovf_clr", 32'(a_ovf), 32'd0);
      idle();
      for (int i = 0; i < 64; i++) begin
         pop_i = 1'b1;
         step();
         chk("ovf_drain", 32'(a_data), (i == 63) ? 32'hBB : 32'(i + 1));
      end
      idle();
      chk("ovf_drain_empty", 32'(a_empty), 32'd1);

      // Push+pop on empty
      data_i = 8'h55; push_i = 1'b1; pop_i = 1'b1;
      step();
      chk("udf_set", 32'(a_udf), 32'd1);
      chk("udf_level", 32'(a_level), 32'd1);
      idle(); pop_i = 1'b1;
      step();
      chk("udf_pop_data", 32'(a_data), 32'h55);
      chk("udf_pop_level", 32'(a_level), 32'd0);
      idle(); clr_err_i = 1'b1;
      step();
      chk("udf_clr", 32'(a_udf), 32'd0);
      idle();

      // Flush
      for (int i = 0; i < 10; i++) begin
         data_i = 8'hC0 + 8'(i); push_i = 1'b1;
         step();
      end
      data_i = 8'hEE; flush_i = 1'b1;
      step();
      chk("flush_level", 32'(a_level), 32'd0);
      chk("flush_empty", 32'(a_empty), 32'd1);
      chk("flush_ovf", 32'(a_ovf), 32'd0);
      chk("flush_data_hold", 32'(a_data), 32'h55);
      push_i = 1'b0; pop_i = 1'b1;
      step();
      chk("flush_pop_udf", 32'(a_udf), 32'd0);
      idle(); data_i = 8'h12; push_i = 1'b1;
      step();
      idle(); pop_i = 1'b1;
      step();
      chk("post_flush_data", 32'(a_data), 32'h12);
      chk("post_flush_level", 32'(a_level), 32'd0);
      idle();

      // Random traffic on the 4-deep FIFO against a reference queue
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      q.delete();
      m_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
      for (int n = 0; n < 100; n++) begin
         push_i    = 1'($urandom_range(0, 1));
         pop_i     = 1'($urandom_range(0, 1));
         clr_err_i = ($urandom_range(0, 7) == 0);
         data_i    = 8'($urandom);
         pok = pop_i && (q.size() != 0);
         wok = push_i && ((q.size() < 4) || pok);
         m_ovf = (push_i && !wok) || (m_ovf && !clr_err_i);
         m_udf = (pop_i && !pok) || (m_udf && !clr_err_i);
         if (pok) m_data = q.pop_front();
         if (wok) q.push_back(data_i);
         step();
         chk("rnd_data", 32'(b_data), 32'(m_data));
         chk("rnd_level", 32'(b_level), 32'(q.size()));
         chk("rnd_full", 32'(b_full), 32'(q.size() == 4));
         chk("rnd_empty", 32'(b_empty), 32'(q.size() == 0));
         chk("rnd_afull", 32'(b_af), 32'(q.size() >= 3));
         chk("rnd_aempty", 32'(b_ae), 32'(q.size() <= 1));
         chk("rnd_ovf", 32'(b_ovf), 32'(m_ovf));
         chk("rnd_udf", 32'(b_udf), 32'(m_udf));
      end
      idle();

      // FWFT instance
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      data_i = 8'h11; push_i = 1'b1;
      step();
      chk("fwft_empty_fall", 32'(c_empty), 32'd0);
      chk("fwft_first", 32'(c_data), 32'h11);
      data_i = 8'h22;
      step();
      chk("fwft_hold", 32'(c_data), 32'h11);
      chk("fwft_level2", 32'(c_level), 32'd2);
      chk("fwft_aempty2", 32'(c_ae), 32'd1);
      push_i = 1'b0; pop_i = 1'b1;
      step();
      chk("fwft_next", 32'(c_data), 32'h22);
      chk("fwft_level1", 32'(c_level), 32'd1);
      data_i = 8'h33; push_i = 1'b1; pop_i = 1'b1;
      step();
      chk("fwft_pp_data", 32'(c_data), 32'h33);
      chk("fwft_pp_level", 32'(c_level), 32'd1);
      data_i = 8'h44; pop_i = 1'b0;
      step();
      chk("fwft_push_hold", 32'(c_data), 32'h33);
      push_i = 1'b0; pop_i = 1'b1;
      step();
      chk("fwft_pop2", 32'(c_data), 32'h44);
      data_i = 8'h55; push_i = 1'b1; pop_i = 1'b0;
      step();
      idle();

      // Asynchronous reset mid-stream, checked before the next clock edge
      rst_i = 1'b1;
      #2;
      chk("arst_level", 32'(c_level), 32'd0);
      chk("arst_empty", 32'(c_empty), 32'd1);
      chk("arst_full", 32'(c_full), 32'd0);
      chk("arst_data", 32'(c_data), 32'd0);
      chk("arst_afull", 32'(c_af), 32'd0);
      chk("arst_aempty", 32'(c_ae), 32'd1);
      chk("arst_ovf", 32'(c_ovf), 32'd0);
      chk("arst_udf", 32'(c_udf), 32'd0);
      chk("arst_big_udf", 32'(a_udf), 32'd0);
      chk("arst_big_data", 32'(a_data), 32'd0);
      step();
      rst_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
